// File: rtl/spi_host_initiator.sv
// SPI mode-0 host for the 4-byte configuration frame {instr, addr[15:8], addr[7:0], data}.
// SPI_CLK is divided from SCLK; the byte shifted in on MISO during the data byte is returned.
module spi_host_initiator #(
    parameter int unsigned HALF_PERIOD = 2,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic        SCLK,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_instr,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        SS_n,
    output logic        SPI_CLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int unsigned HW = $clog2(HALF_PERIOD + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [HW-1:0] HP_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSetup   = 3'd1;
    localparam logic [2:0] StShiftHi = 3'd2;
    localparam logic [2:0] StShiftLo = 3'd3;
    localparam logic [2:0] StEnd     = 3'd4;
    localparam logic [2:0] StGap     = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [HW-1:0] hp_cnt_q, hp_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic          last_q, last_d;
    logic [31:0]   tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          ss_n_q, ss_n_d;
    logic          spi_clk_q, spi_clk_d;
    logic          mosi_q, mosi_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        state_d     = state_q;
        hp_cnt_d    = hp_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        last_d      = last_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        ss_n_d      = ss_n_q;
        spi_clk_d   = spi_clk_q;
        mosi_d      = mosi_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = StSetup;
                    tx_d        = {cmd_instr, cmd_addr, cmd_wdata};
                    mosi_d      = cmd_instr[7];
                    ss_n_d      = 1'b0;
                    spi_clk_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    hp_cnt_d    = '0;
                    bit_cnt_d   = '0;
                    last_d      = 1'b0;
                end
            end

            StSetup: begin
                if (hp_cnt_q == HP_LAST) begin
                    state_d   = StShiftHi;
                    hp_cnt_d  = '0;
                    spi_clk_d = 1'b1;
                    rx_d      = {rx_q[6:0], MISO};
                end else begin
                    hp_cnt_d = hp_cnt_q + HW'(1);
                end
            end

            StShiftHi: begin
                if (hp_cnt_q == HP_LAST) begin
                    state_d   = StShiftLo;
                    hp_cnt_d  = '0;
                    spi_clk_d = 1'b0;
                    // Bit 31 keeps MOSI through its low phase as hold time.
                    if (bit_cnt_q == 5'd31) begin
                        last_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        tx_d      = {tx_q[30:0], 1'b0};
                        mosi_d    = tx_q[30];
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + HW'(1);
                end
            end

            StShiftLo: begin
                if (hp_cnt_q == HP_LAST) begin
                    hp_cnt_d = '0;
                    if (last_q) begin
                        state_d     = StEnd;
                        ss_n_d      = 1'b1;
                        mosi_d      = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rx_q;
                    end else begin
                        state_d   = StShiftHi;
                        spi_clk_d = 1'b1;
                        rx_d      = {rx_q[6:0], MISO};
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + HW'(1);
                end
            end

            StEnd: begin
                state_d   = StGap;
                gap_cnt_d = '0;
            end

            StGap: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d     = StIdle;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end

            default: begin
                state_d     = StIdle;
                ss_n_d      = 1'b1;
                spi_clk_d   = 1'b0;
                mosi_d      = 1'b0;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            hp_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            last_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            ss_n_q      <= 1'b1;
            spi_clk_q   <= 1'b0;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            hp_cnt_q    <= hp_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            last_q      <= last_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            ss_n_q      <= ss_n_d;
            spi_clk_q   <= spi_clk_d;
            mosi_q      <= mosi_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign SPI_CLK   = spi_clk_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_host_initiator.sv
// Directed bench for spi_host_initiator: default-timing instance with a mode-0 slave model,
// plus a HALF_PERIOD=1 / GAP_CYCLES=1 instance with MISO tied high.
module tb_spi_host_initiator;

    logic SCLK = 1'b0;
    logic RESET;
    always #5 SCLK = ~SCLK;

    logic        cmd_valid0, cmd_ready0, rsp_valid0, busy0, ss_n0, spi_clk0, mosi0, MISO0;
    logic [7:0]  cmd_instr0, cmd_wdata0, rsp_rdata0;
    logic [15:0] cmd_addr0;

    logic        cmd_valid1, cmd_ready1, rsp_valid1, busy1, ss_n1, spi_clk1, mosi1, MISO1;
    logic [7:0]  cmd_instr1, cmd_wdata1, rsp_rdata1;
    logic [15:0] cmd_addr1;
    assign MISO1 = 1'b1;

    spi_host_initiator #(.HALF_PERIOD(2), .GAP_CYCLES(4)) u_dut0 (
        .SCLK(SCLK), .RESET(RESET), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_instr(cmd_instr0), .cmd_addr(cmd_addr0), .cmd_wdata(cmd_wdata0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .busy(busy0), .SS_n(ss_n0),
        .SPI_CLK(spi_clk0), .MOSI(mosi0), .MISO(MISO0)
    );

    spi_host_initiator #(.HALF_PERIOD(1), .GAP_CYCLES(1)) u_dut1 (
        .SCLK(SCLK), .RESET(RESET), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_instr(cmd_instr1), .cmd_addr(cmd_addr1), .cmd_wdata(cmd_wdata1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1), .SS_n(ss_n1),
        .SPI_CLK(spi_clk1), .MOSI(mosi1), .MISO(MISO1)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Mode-0 slave model: drives 0x3C during byte 3 (frame bits 24..31), ones before it.
    localparam logic [7:0] SLAVE_BYTE = 8'h3C;
    function automatic logic slave_bit(input int idx);
        logic [7:0] b;
        b = SLAVE_BYTE;
        if (idx < 24) return 1'b1;
        else if (idx < 32) return b[31-idx];
        else return 1'b0;
    endfunction

    int          rises0 = 0, low_run0 = 0, last_low0 = 0, high_run0 = 0, last_high0 = 0;
    int          rsp_cnt0 = 0, idx0 = 0;
    logic        prev_clk0 = 1'b0, prev_ss0 = 1'b1;
    logic [31:0] mosi_sr0 = '0;

    always @(negedge SCLK) begin
        if (spi_clk0 && !prev_clk0) begin
            rises0++;
            mosi_sr0 = {mosi_sr0[30:0], mosi0};
        end
        if (!ss_n0) begin
            if (prev_ss0) begin
                last_high0 = high_run0;
                low_run0 = 0;
            end
            low_run0++;
        end else begin
            if (!prev_ss0) begin
                last_low0 = low_run0;
                high_run0 = 0;
            end
            high_run0++;
        end
        if (rsp_valid0) rsp_cnt0++;
        if (ss_n0) idx0 = 0;
        else if (prev_clk0 && !spi_clk0) idx0++;
        MISO0 = slave_bit(idx0);
        prev_clk0 = spi_clk0;
        prev_ss0 = ss_n0;
    end

    int          rises1 = 0, low_run1 = 0, last_low1 = 0;
    logic        prev_clk1 = 1'b0, prev_ss1 = 1'b1;
    logic [31:0] mosi_sr1 = '0;

    always @(negedge SCLK) begin
        if (spi_clk1 && !prev_clk1) begin
            rises1++;
            mosi_sr1 = {mosi_sr1[30:0], mosi1};
        end
        if (!ss_n1) begin
            if (prev_ss1) low_run1 = 0;
            low_run1++;
        end else if (!prev_ss1) begin
            last_low1 = low_run1;
        end
        prev_clk1 = spi_clk1;
        prev_ss1 = ss_n1;
    end

    int cyc = 0;
    int acc_cnt0 = 0, acc_last0 = 0, acc_gap0 = 0;
    always @(posedge SCLK) cyc <= cyc + 1;
    always @(posedge SCLK) begin
        if (cmd_valid0 && cmd_ready0 && !RESET) begin
            acc_cnt0++;
            acc_gap0 = cyc - acc_last0;
            acc_last0 = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send0(input logic [7:0] i, input logic [15:0] a, input logic [7:0] w,
                         input logic keep);
        logic ok;
        ok = 1'b0;
        cmd_instr0 = i;
        cmd_addr0  = a;
        cmd_wdata0 = w;
        cmd_valid0 = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (cmd_ready0) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!keep) cmd_valid0 = 1'b0;
        check("accept0_in_time", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp0();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (rsp_valid0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("rsp0_in_time", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int r, c, a, n;
        logic ok, prev;

        RESET = 1'b1;
        cmd_valid0 = 1'b0; cmd_instr0 = '0; cmd_addr0 = '0; cmd_wdata0 = '0;
        cmd_valid1 = 1'b0; cmd_instr1 = '0; cmd_addr1 = '0; cmd_wdata1 = '0;
        ticks(3);
        check("rst_ss_n", 32'(ss_n0), 32'd1);
        check("rst_spi_clk", 32'(spi_clk0), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready0), 32'd1);
        RESET = 1'b0;
        tick();
        check("idle_mosi", 32'(mosi0), 32'd0);
        check("idle_busy", 32'(busy0), 32'd0);
        check("idle_rsp_valid", 32'(rsp_valid0), 32'd0);
        check("idle_rsp_rdata", 32'(rsp_rdata0), 32'd0);
        check("idle_busy1", 32'(busy1), 32'd0);

        // Write frame with readback of the slave byte.
        r = rises0; c = rsp_cnt0;
        send0(8'h01, 16'h0005, 8'hA5, 1'b0);
        check("setup_ss_n", 32'(ss_n0), 32'd0);
        check("setup_mosi_bit31", 32'(mosi0), 32'd0);
        check("setup_busy", 32'(busy0), 32'd1);
        check("setup_cmd_ready", 32'(cmd_ready0), 32'd0);
        tick();
        check("setup_spi_clk_low", 32'(spi_clk0), 32'd0);
        tick();
        check("first_rise_after_half", 32'(spi_clk0), 32'd1);
        wait_rsp0();
        check("rdata_at_valid", 32'(rsp_rdata0), 32'h3C);
        tick();
        check("rsp_valid_one_cycle", 32'(rsp_valid0), 32'd0);
        check("ss_low_cycles", 32'(last_low0), 32'd130);
        check("spi_rises", 32'(rises0 - r), 32'd32);
        check("mosi_frame", mosi_sr0, 32'h010005A5);
        check("rsp_pulses", 32'(rsp_cnt0 - c), 32'd1);
        ticks(20);
        check("rdata_held", 32'(rsp_rdata0), 32'h3C);
        check("ready_after_gap", 32'(cmd_ready0), 32'd1);

        // Back-to-back with cmd_valid held; inputs change while frame A is in flight.
        a = acc_cnt0;
        send0(8'h80, 16'h1234, 8'h5A, 1'b1);
        cmd_instr0 = 8'h42; cmd_addr0 = 16'hBEEF; cmd_wdata0 = 8'h11;
        wait_rsp0();
        tick();
        check("b2b_frame_a", mosi_sr0, 32'h8012345A);
        send0(8'h42, 16'hBEEF, 8'h11, 1'b0);
        check("accept_to_accept", 32'(acc_gap0), 32'd136);
        tick();
        check("ss_high_between", 32'(last_high0), 32'd6);
        ticks(10);
        cmd_valid0 = 1'b1; cmd_instr0 = 8'hFF; cmd_addr0 = 16'hFFFF; cmd_wdata0 = 8'hFF;
        check("midframe_not_ready", 32'(cmd_ready0), 32'd0);
        tick();
        cmd_valid0 = 1'b0;
        wait_rsp0();
        tick();
        check("b2b_frame_b", mosi_sr0, 32'h42BEEF11);
        ticks(200);
        check("no_extra_frame", 32'(acc_cnt0 - a), 32'd2);

        // Reset at SPI rise #17, then a clean frame accepted on the first edge after release.
        send0(8'h55, 16'hAAAA, 8'h55, 1'b0);
        n = 0; ok = 1'b0; prev = spi_clk0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (spi_clk0 && !prev) n++;
            prev = spi_clk0;
            if (n == 17) begin
                ok = 1'b1;
                break;
            end
        end
        check("rise17_reached", 32'(ok), 32'd1);
        c = rsp_cnt0;
        RESET = 1'b1;
        #1;
        check("abort_ss_n", 32'(ss_n0), 32'd1);
        check("abort_spi_clk", 32'(spi_clk0), 32'd0);
        check("abort_rdata", 32'(rsp_rdata0), 32'd0);
        check("abort_ready", 32'(cmd_ready0), 32'd1);
        cmd_instr0 = 8'hC3; cmd_addr0 = 16'h0F0F; cmd_wdata0 = 8'h96; cmd_valid0 = 1'b1;
        ticks(3);
        RESET = 1'b0;
        r = rises0;
        tick();
        cmd_valid0 = 1'b0;
        check("accept_first_edge", 32'(ss_n0), 32'd0);
        wait_rsp0();
        tick();
        check("post_reset_pulses", 32'(rsp_cnt0 - c), 32'd1);
        check("post_reset_rises", 32'(rises0 - r), 32'd32);
        check("post_reset_ss_low", 32'(last_low0), 32'd130);
        check("post_reset_frame", mosi_sr0, 32'hC30F0F96);
        check("post_reset_rdata", 32'(rsp_rdata0), 32'h3C);

        // HALF_PERIOD=1, GAP_CYCLES=1 instance.
        r = rises1;
        cmd_instr1 = 8'h00; cmd_addr1 = 16'h0000; cmd_wdata1 = 8'hFF; cmd_valid1 = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        cmd_valid1 = 1'b0;
        check("hp1_accept", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (rsp_valid1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("hp1_rsp_in_time", 32'(ok), 32'd1);
        tick();
        check("hp1_rises", 32'(rises1 - r), 32'd32);
        check("hp1_ss_low", 32'(last_low1), 32'd65);
        check("hp1_rdata", 32'(rsp_rdata1), 32'hFF);
        check("hp1_frame", mosi_sr1, 32'h000000FF);
        ticks(3);
        check("hp1_idle_ready", 32'(cmd_ready1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_host_initiator.md
Name: spi_host_initiator

Overview:
- SPI initiator (host) side of the chip's byte-oriented SPI configuration protocol.
- Each 4-byte frame, sent MSB first in SPI mode 0, carries: instruction, address MSB, address LSB, data.
- Used by the FPGA companion/test harness to write configuration memory and ready flags, and to read back the byte shifted out on MISO during the data byte.
- Runs on system clock SCLK; generates the SPI serial clock SPI_CLK by division.

Parameters:
- HALF_PERIOD, 2, SCLK cycles per SPI_CLK half-period; legal range >=1.
- GAP_CYCLES, 4, SCLK cycles SS_n stays high after a frame before the next command is accepted; legal range >=1.

Ports:
- SCLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on SCLK edge with cmd_valid&cmd_ready.
- cmd_instr  in  8  instruction byte (frame byte 0).
- cmd_addr  in  16  [15:8] is frame byte 1, [7:0] is frame byte 2.
- cmd_wdata  in  8  data byte (frame byte 3).
- rsp_valid  out  1  one-cycle pulse at frame end.
- rsp_rdata  out  8  MISO bits captured during byte 3; held until the next frame ends.
- busy  out  1  high from acceptance through end of GAP.
- SS_n  out  1  slave select, active-low.
- SPI_CLK  out  1  serial clock, idle low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.

Behaviour:
- Reset values (async, immediate): SS_n=1, SPI_CLK=0, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, state IDLE.
- All outputs are registered.
- Command capture: on acceptance, latch {cmd_instr, cmd_addr, cmd_wdata} into a 32-bit shift register. Later changes on the cmd_* inputs have no effect on the frame in flight.
- cmd_valid while not in IDLE is ignored, not queued.
- States:
  - IDLE -> SETUP on accept.
  - SETUP -> SHIFT_HI after HALF_PERIOD cycles.
  - SHIFT_HI <-> SHIFT_LO, one per half-period.
  - SHIFT_LO after bit 31 -> END.
  - END -> GAP.
  - GAP -> IDLE after GAP_CYCLES.
- SETUP: cycle after accept SS_n=0 and MOSI=frame bit31 (instr[7]); SPI_CLK=0 for HALF_PERIOD cycles.
- SHIFT_HI: SPI_CLK=1 for HALF_PERIOD cycles. On the cycle SPI_CLK is driven 0->1, MISO is sampled into the receive shift register (LSB in, left shift).
- SHIFT_LO: SPI_CLK=0 for HALF_PERIOD cycles. On entry MOSI advances to the next bit. After bit 31's low phase (the hold time), go to END.
- MOSI stays stable across each full high phase.
- Bit counter: 5 bits, 0..31, increments on each SHIFT_HI->SHIFT_LO transition; terminal count 31 ends shifting.
- Half-period counter width: clog2(HALF_PERIOD+1).
- END (1 cycle): SS_n=1, MOSI=0, rsp_valid=1, rsp_rdata = last 8 sampled bits (the byte-3 window).
- GAP: SS_n=1 for GAP_CYCLES cycles. cmd_ready returns to 1 on IDLE entry; busy drops at the same time.
- Timing: SS_n low for exactly 65*HALF_PERIOD cycles; exactly 32 SPI_CLK rising edges per frame.
- Accept-to-accept minimum: 1+65*HALF_PERIOD+1+GAP_CYCLES cycles (136 at defaults).
- HALF_PERIOD=1: SPI_CLK toggles every SCLK cycle; SS_n low 65 cycles.
- RESET mid-frame: immediate abort. SS_n=1, SPI_CLK=0, no rsp_valid pulse, rsp_rdata cleared, IDLE after release.
- Reset release: a command may be accepted on the first SCLK edge after RESET falls.

Test Plan:
- Write frame, defaults: instr=0x01, addr=0x0005, wdata=0xA5 -> MOSI bits sampled at the 32 SPI_CLK rises = 0x010005A5; SS_n low 130 cycles; rsp_valid single pulse.
- Readback: slave model drives 0x3C on MISO during byte 3 (changing on falling edges) -> rsp_rdata=0x3C at rsp_valid and held afterward.
- Back-to-back: cmd_valid held high with two commands -> second accepted exactly 136 cycles after first; SS_n high >= GAP_CYCLES+1 between frames.
- cmd_valid pulsed and cmd_* changed mid-frame -> cmd_ready=0, frame content unchanged, no extra frame.
- RESET asserted at SPI rise #17 -> SS_n=1 and SPI_CLK=0 immediately; no rsp_valid; next command produces a clean full frame.
- HALF_PERIOD=1, GAP_CYCLES=1: wdata=0xFF, MISO tied 1 -> 32 rises, SS_n low 65 cycles, rsp_rdata=0xFF.
